// File: rtl/operand_loader_if.sv
// Valid/ready word stream shared by the operand input and the result output.
interface operand_loader_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/operand_loader.sv
// Collects eight operand words, fires the compute core once, then captures
// its result and offers it downstream, counting completed batches.
module operand_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  operand_loader_if.slave    in_s,
  output logic [WIDTH-1:0]   o1,
  output logic [WIDTH-1:0]   o2,
  output logic [WIDTH-1:0]   o3,
  output logic [WIDTH-1:0]   o4,
  output logic [WIDTH-1:0]   o5,
  output logic [WIDTH-1:0]   o6,
  output logic [WIDTH-1:0]   o7,
  output logic [WIDTH-1:0]   o8,
  output logic               start,
  input  logic               core_done,
  input  logic [WIDTH-1:0]   core_result,
  operand_loader_if.master   out_s,
  output logic [CNT_W-1:0]   batch_cnt
);

  localparam int unsigned NUM_OPS = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   slot_q [NUM_OPS];
  logic [WIDTH-1:0]   out_data_q;
  logic [CNT_W-1:0]   batch_q;
  logic               in_ready_q;
  logic               start_q;
  logic               out_valid_q;
  logic               accept;
  logic               capture;
  logic               hand_off;

  // Next-state decode; abort overrides every transition and blocks writes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    accept   = 1'b0;
    capture  = 1'b0;
    hand_off = 1'b0;
    if (abort) begin
      state_d = S_LOAD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_s.valid && in_ready_q) begin
            accept = 1'b1;
            if (idx_q == IDX_W'(NUM_OPS - 1)) begin
              state_d = S_FIRE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_FIRE: state_d = S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_s.ready) begin
            hand_off = 1'b1;
            state_d  = S_LOAD;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Handshake flags are registered decodes of the next state, so they
  // always match the state they describe without any input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      out_data_q  <= '0;
      batch_q     <= '0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == S_LOAD);
      start_q     <= (state_d == S_FIRE);
      out_valid_q <= (state_d == S_HOLD);
      if (accept) begin
        slot_q[idx_q] <= in_s.data;
      end
      if (capture) begin
        out_data_q <= core_result;
      end
      if (hand_off) begin
        batch_q <= batch_q + CNT_W'(1);
      end
    end
  end

  assign in_s.ready  = in_ready_q;
  assign out_s.valid = out_valid_q;
  assign out_s.data  = out_data_q;
  assign start       = start_q;
  assign batch_cnt   = batch_q;

  assign o1 = slot_q[0];
  assign o2 = slot_q[1];
  assign o3 = slot_q[2];
  assign o4 = slot_q[3];
  assign o5 = slot_q[4];
  assign o6 = slot_q[5];
  assign o7 = slot_q[6];
  assign o8 = slot_q[7];

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus queues expected operands and
// results, a negedge monitor checks them when start or a result handshake appears.
module tb_operand_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       abort = 1'b0;
  word_t      o1, o2, o3, o4, o5, o6, o7, o8;
  logic       start;
  logic       core_pulse = 1'b0;
  logic       core_level = 1'b0;
  word_t      pulse_result = '0;
  word_t      level_result = '0;
  logic       core_done;
  word_t      core_result;
  cnt_t       batch_cnt;

  logic       core_auto = 1'b1;
  word_t      core_ret = '0;

  int         checks = 0;
  int         errors = 0;

  word_t      exp_ops[$];
  word_t      exp_res[$];
  cnt_t       exp_cnt[$];

  always #5 clk = ~clk;

  assign core_done   = core_pulse | core_level;
  assign core_result = core_level ? level_result : pulse_result;

  operand_loader_if #(.WIDTH(WIDTH)) in_if ();
  operand_loader_if #(.WIDTH(WIDTH)) out_if ();

  operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .in_s        (in_if),
    .o1          (o1),
    .o2          (o2),
    .o3          (o3),
    .o4          (o4),
    .o5          (o5),
    .o6          (o6),
    .o7          (o7),
    .o8          (o8),
    .start       (start),
    .core_done   (core_done),
    .core_result (core_result),
    .out_s       (out_if),
    .batch_cnt   (batch_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural core: returns core_ret as a one-cycle done, 4 cycles after start.
  initial begin
    forever begin
      @(negedge clk);
      if (start && core_auto) begin
        repeat (4) @(posedge clk);
        #1;
        core_pulse   = 1'b1;
        pulse_result = core_ret;
        @(posedge clk);
        #1;
        core_pulse = 1'b0;
      end
    end
  end

  // Monitor: operands checked on start, results checked on the out handshake.
  word_t acc[$];
  bit    last8 = 1'b0;
  word_t ops_now [8];

  always @(negedge clk) begin
    if (!rst || abort) begin
      acc.delete();
      last8 = 1'b0;
    end else begin
      if (start) begin
        check("start_after_8th_accept", 64'(last8), 64'(1));
        check("accept_count", 64'(acc.size()), 64'(8));
        ops_now = '{o1, o2, o3, o4, o5, o6, o7, o8};
        for (int i = 0; i < 8; i++) begin
          if (exp_ops.size() == 0) begin
            check("unexpected_start", 64'(1), 64'(0));
            break;
          end
          check($sformatf("op%0d", i + 1), 64'(ops_now[i]), 64'(exp_ops.pop_front()));
        end
        acc.delete();
      end
      last8 = 1'b0;
      if (in_if.valid && in_if.ready) begin
        acc.push_back(in_if.data);
        last8 = (acc.size() == 8);
      end
      if (out_if.valid && out_if.ready) begin
        if (exp_res.size() == 0) begin
          check("unexpected_result", 64'(1), 64'(0));
        end else begin
          check("out_data", 64'(out_if.data), 64'(exp_res.pop_front()));
          check("cnt_at_handshake", 64'(batch_cnt), 64'(exp_cnt.pop_front()));
        end
      end
    end
  end

  task automatic send_word(input word_t w, input bit gap);
    int n = 0;
    in_if.valid = 1'b1;
    in_if.data  = w;
    while (!in_if.ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", 64'(in_if.ready), 64'(1));
    @(posedge clk);
    #1;
    if (gap) begin
      in_if.valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_batch(input word_t base, input bit gap, input int n, input bit expect_fire);
    if (expect_fire) begin
      for (int i = 0; i < 8; i++) exp_ops.push_back(base + word_t'(i));
    end
    for (int i = 0; i < n; i++) send_word(base + word_t'(i), gap);
    in_if.valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_if.valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_wait", 64'(out_if.valid), 64'(1));
  endtask

  task automatic drain(input int hold, input word_t exp_data, input cnt_t cnt_before);
    exp_res.push_back(exp_data);
    exp_cnt.push_back(cnt_before);
    wait_out_valid();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 64'(out_if.valid), 64'(1));
      check("bp_out_data", 64'(out_if.data), 64'(exp_data));
      check("bp_in_ready", 64'(in_if.ready), 64'(0));
      check("bp_batch_cnt", 64'(batch_cnt), 64'(cnt_before));
    end
    out_if.ready = 1'b1;
    @(posedge clk);
    #1;
    out_if.ready = 1'b0;
    check("post_batch_cnt", 64'(batch_cnt), 64'(cnt_t'(cnt_before + cnt_t'(1))));
    check("post_in_ready", 64'(in_if.ready), 64'(1));
    check("post_out_valid", 64'(out_if.valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // Reset values
    #1;
    check("rst_in_ready", 64'(in_if.ready), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_out_valid", 64'(out_if.valid), 64'(0));
    check("rst_o1", 64'(o1), 64'(0));
    check("rst_out_data", 64'(out_if.data), 64'(0));
    check("rst_batch_cnt", 64'(batch_cnt), 64'(0));
    #11;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 64'(in_if.ready), 64'(1));

    // Basic batch, in_valid held high
    core_ret = 36;
    send_batch(1, 1'b0, 8, 1'b1);
    drain(0, 36, 0);

    // Gapped input
    core_ret = 32'h55;
    send_batch(10, 1'b1, 8, 1'b1);
    drain(0, 32'h55, 1);

    // Backpressure
    core_ret = 32'hDEADBEEF;
    send_batch(100, 1'b0, 8, 1'b1);
    drain(20, 32'hDEADBEEF, 2);

    // Level done held through HOLD and into the next LOAD
    core_auto = 1'b0;
    send_batch(200, 1'b0, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    level_result = 32'hA5A5;
    core_level   = 1'b1;
    drain(0, 32'hA5A5, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("level_no_recapture", 64'(out_if.valid), 64'(0));
    end
    send_batch(300, 1'b0, 8, 1'b1);
    core_level = 1'b0;
    core_ret   = 32'h77;
    core_auto  = 1'b1;
    drain(0, 32'h77, 4);

    // Abort after 5 words
    send_batch(1, 1'b0, 5, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_start", 64'(start), 64'(0));
    check("abort_in_ready", 64'(in_if.ready), 64'(1));
    check("abort_o1_kept", 64'(o1), 64'(1));
    check("abort_o5_kept", 64'(o5), 64'(5));
    check("abort_cnt", 64'(batch_cnt), 64'(5));
    core_ret = 32'h99;
    send_batch(21, 1'b0, 8, 1'b1);
    drain(0, 32'h99, 5);

    // Abort during HOLD drops the result uncounted
    core_ret = 32'hBEEF;
    send_batch(400, 1'b0, 8, 1'b1);
    wait_out_valid();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("hold_abort_valid", 64'(out_if.valid), 64'(0));
    check("hold_abort_data", 64'(out_if.data), 64'(32'hBEEF));
    check("hold_abort_cnt", 64'(batch_cnt), 64'(6));
    check("hold_abort_in_ready", 64'(in_if.ready), 64'(1));

    // Reset asserted between edges while in WAIT
    send_batch(40, 1'b0, 8, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_o1", 64'(o1), 64'(0));
    check("mid_rst_o8", 64'(o8), 64'(0));
    check("mid_rst_out_data", 64'(out_if.data), 64'(0));
    check("mid_rst_batch_cnt", 64'(batch_cnt), 64'(0));
    check("mid_rst_in_ready", 64'(in_if.ready), 64'(0));
    check("mid_rst_start", 64'(start), 64'(0));
    check("mid_rst_out_valid", 64'(out_if.valid), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 64'(in_if.ready), 64'(1));
    check("mid_rel_batch_cnt", 64'(batch_cnt), 64'(0));

    repeat (8) @(posedge clk);
    #1;
    check("ops_queue_empty", 64'(exp_ops.size()), 64'(0));
    check("res_queue_empty", 64'(exp_res.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
